// File: rtl/bus_sram_responder.sv
// Word-addressed SRAM slave on the shared processor bus: single/burst reads and writes with burst range checks.
// Optional BUS_SRAM_RESPONDER_BUSY_EN inserts a one-cycle busyOut stall after every accepted write beat.
module bus_sram_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int unsigned ADDR_WIDTH   = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned TAG_LSB  = ADDR_WIDTH + 2;
    localparam int unsigned BEAT_W   = 9;

    typedef enum logic [2:0] {
        IDLE,
        READ_PREP,
        READ,
        READ_END,
        WRITE,
        ERROR
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   word_addr_q;
    logic [BEAT_W-1:0]       beats_q;
    logic [3:0]              byte_en_q;
    logic                    busy_q;
    logic [31:0]             mem [DEPTH];
    logic [31:0]             mem_rd_q;

    logic                    in_window_c;
    logic                    bad_request_c;
    logic [ADDR_WIDTH:0]     last_word_c;
    logic                    accept_beat_c;
    logic                    write_word_c;

    // Request decode and write-beat acceptance
    always_comb begin
        in_window_c   = (addressDataIn[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
        last_word_c   = (ADDR_WIDTH+1)'(addressDataIn[TAG_LSB-1:2])
                      + (ADDR_WIDTH+1)'(burstSizeIn);
        // The carry bit set means the burst would run past the last word.
        bad_request_c = (addressDataIn[1:0] != 2'b00) || last_word_c[ADDR_WIDTH];
        accept_beat_c = (state_q == WRITE) && dataValidIn && !busy_q;
        write_word_c  = accept_beat_c && (beats_q != '0) && reset;
    end

    // Storage: one write port with byte lanes, one read port with a cycle of latency; no reset on contents
    always_ff @(posedge clock) begin
        mem_rd_q <= mem[word_addr_q];
        if (write_word_c) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_q[i]) begin
                    mem[word_addr_q][8*i +: 8] <= addressDataIn[8*i +: 8];
                end
            end
        end
    end

    // Transaction sequencing and registered bus outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q           <= IDLE;
            word_addr_q       <= '0;
            beats_q           <= '0;
            byte_en_q         <= '0;
            busy_q            <= 1'b0;
            addressDataOut    <= '0;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
        end else begin
            addressDataOut    <= '0;
            dataValidOut      <= 1'b0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
`ifdef BUS_SRAM_RESPONDER_BUSY_EN
            busy_q            <= accept_beat_c;
`else
            busy_q            <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (beginTransactionIn && in_window_c) begin
                        word_addr_q <= addressDataIn[TAG_LSB-1:2];
                        byte_en_q   <= byteEnablesIn;
                        if (bad_request_c) begin
                            state_q <= ERROR;
                        end else if (readNotWriteIn) begin
                            beats_q <= BEAT_W'(burstSizeIn);
                            state_q <= READ_PREP;
                        end else begin
                            beats_q <= BEAT_W'(burstSizeIn) + BEAT_W'(1);
                            state_q <= WRITE;
                        end
                    end
                end
                READ_PREP: begin
                    word_addr_q <= word_addr_q + ADDR_WIDTH'(1);
                    state_q     <= READ;
                end
                READ: begin
                    addressDataOut <= mem_rd_q;
                    dataValidOut   <= 1'b1;
                    word_addr_q    <= word_addr_q + ADDR_WIDTH'(1);
                    if (beats_q == '0) begin
                        state_q <= READ_END;
                    end else begin
                        beats_q <= beats_q - BEAT_W'(1);
                    end
                end
                READ_END: begin
                    endTransactionOut <= 1'b1;
                    state_q           <= IDLE;
                end
                WRITE: begin
                    if (write_word_c) begin
                        word_addr_q <= word_addr_q + ADDR_WIDTH'(1);
                        beats_q     <= beats_q - BEAT_W'(1);
                    end
                    if (endTransactionIn) begin
                        state_q <= IDLE;
                    end
                end
                ERROR: begin
                    busErrorOut       <= 1'b1;
                    endTransactionOut <= 1'b1;
                    state_q           <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busyOut = busy_q;

endmodule

// File: doc/bus_sram_responder.md
# bus_sram_responder

Word-addressed on-chip SRAM that acts as a slave (responder) on the shared processor bus used by the DMA controller and CPU. It decodes bus transactions in a fixed address window, serves single and burst reads and writes, and signals errors for illegal bursts. It gives the DMA master a deterministic target for bring-up and throughput measurement.

## Interface
- `BASE_ADDRESS`, 32'h5000_0000 — byte base address of the window; low `ADDR_WIDTH+2` bits ignored.
- `ADDR_WIDTH`, 9 — log2 of memory depth in 32-bit words (default 512 words).
- `clock` in 1 — single clock; all state changes on rising edge.
- `reset` in 1 — synchronous, active-low (0 = reset).
- `beginTransactionIn` in 1 — one-cycle start strobe from the master.
- `addressDataIn` in 32 — byte address when `beginTransactionIn`=1; write data otherwise.
- `byteEnablesIn` in 4 — byte lane enables, sampled with `beginTransactionIn`.
- `burstSizeIn` in 8 — words in transfer minus 1, sampled with `beginTransactionIn`.
- `readNotWriteIn` in 1 — 1 = read, 0 = write, sampled with `beginTransactionIn`.
- `dataValidIn` in 1 — write beat valid.
- `endTransactionIn` in 1 — master terminates a write.
- `addressDataOut` out 32 — read data; 0 when `dataValidOut`=0.
- `dataValidOut` out 1 — read beat valid.
- `endTransactionOut` out 1 — responder terminates a read or error.
- `busErrorOut` out 1 — transaction rejected.
- `busyOut` out 1 — write beat stall.

## Operation
- States: IDLE, READ_PREP, READ, READ_END, WRITE, ERROR.
- IDLE: on `beginTransactionIn`=1 with `addressDataIn[31:ADDR_WIDTH+2]` = `BASE_ADDRESS[31:ADDR_WIDTH+2]`: latch word address `addressDataIn[ADDR_WIDTH+1:2]`, burst count, byte enables, direction. Out-of-window begins ignored (state stays IDLE).
- Error check at accept: `addressDataIn[1:0]`≠0, or word address + `burstSizeIn` > 2^ADDR_WIDTH−1 (compute in ADDR_WIDTH+1 bits, no wrap) → ERROR.
- ERROR: one cycle; drives `busErrorOut`=1 and `endTransactionOut`=1 together; then IDLE. Memory untouched.
- Read: READ_PREP issues first memory read; READ outputs one word per cycle with `dataValidOut`=1, exactly `burstSizeIn`+1 beats, address +1 per beat; READ_END drives `endTransactionOut`=1 one cycle; then IDLE. Byte enables ignored for reads; full words returned.
- Write: WRITE accepts a beat on each edge with `dataValidIn`=1 and `busyOut`=0; writes enabled bytes of `addressDataIn` to current word, address +1. Beats beyond `burstSizeIn`+1 discarded. `endTransactionIn`=1 → IDLE (a beat in the same cycle is still accepted). Responder never drives `endTransactionOut` for writes.
- `beginTransactionIn` outside IDLE ignored.
- Data stored as-is; no byte swapping.

## Timing
- Reset (`reset`=0 at edge): state IDLE; all outputs 0 after that edge; memory contents retained; reset mid-transaction abandons it with no further beats.
- Read latency: begin sampled at edge E; first `dataValidOut` high after edge E+2; last beat after E+2+`burstSizeIn`; `endTransactionOut` after E+3+`burstSizeIn`; IDLE (new begin accepted) from edge E+4+`burstSizeIn`.
- Error: `busErrorOut`/`endTransactionOut` high for the cycle after edge E+1 only.
- Write: WRITE active from edge E+1; first beat acceptable at edge E+1.
- Memory: one read port, one write port, read latency 1 cycle; all outputs registered.

## Configuration
- `BUS_SRAM_RESPONDER_BUSY_EN`: defined → `busyOut`=1 for exactly the one cycle following each accepted write beat (max one beat per two cycles); undefined → `busyOut` tied 0, one beat per cycle.

## Test plan
- Write burst `burstSizeIn`=3 at 0x5000_0010, data 0x11,0x22,0x33,0x44, enables F → read back burst at same address returns same four words, `endTransactionOut` one cycle after fourth beat.
- Single read (`burstSizeIn`=0) at 0x5000_0000 after begin at edge E → `dataValidOut` after E+2, `endTransactionOut` after E+3.
- Write 0xAABBCCDD with enables 4'b0101 over 0x00000000 → read returns 0x00BB00DD.
- Burst `burstSizeIn`=3 at word 510 (0x5000_07F8) or address 0x5000_0002 → one cycle `busErrorOut`=`endTransactionOut`=1, memory unchanged; begin at 0x6000_0000 → no response.
- With `BUS_SRAM_RESPONDER_BUSY_EN`: master holds `dataValidIn`=1 for 4 words → `busyOut` pattern 0,1,0,1,…, all 4 words stored; without macro → 4 beats in 4 cycles.
- `reset`=0 during second beat of 8-word read → outputs 0 next cycle, IDLE; subsequent read returns correct data.
